iic_reg_ctrl: RTL and testbench

//   Register-level I2C master sequencer sitting directly upstream of the I2C
//   bit-shift engine. Turns one register write/read request (device id, 8/16-bit

---
 rtl/iic_reg_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_iic_reg_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_reg_ctrl.sv
// Register-level I2C sequencer: expands one register read/write request
// into the byte-command sequence executed by the downstream bit engine.
module iic_reg_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [6:0]  dev_id,
    input  logic        addr_mode,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        rw_done,
    output logic        err,
    output logic        busy,
    output logic [5:0]  cmd,
    output logic        go,
    output logic [7:0]  tx_data,
    input  logic [7:0]  rx_data,
    input  logic        trans_done,
    input  logic        ack_o
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    localparam logic [5:0] C_WR   = 6'b000001;
    localparam logic [5:0] C_STA  = 6'b000010;
    localparam logic [5:0] C_RD   = 6'b000100;
    localparam logic [5:0] C_STO  = 6'b001000;
    localparam logic [5:0] C_NACK = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_step, w_step_nxt, w_step_sel;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [5:0]    r_cmd, w_cmd_nxt;
    logic [7:0]    r_tx, w_tx_nxt;
    logic [7:0]    r_rd, w_rd_nxt;
    logic          r_go, w_go_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_load, w_last;
    logic [6:0]    r_dev;
    logic          r_mode, r_is_rd;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;

    assign cmd     = r_cmd;
    assign go      = r_go;
    assign tx_data = r_tx;
    assign rd_data = r_rd;
    assign rw_done = r_done;
    assign err     = r_err;
    assign busy    = r_busy;

    assign w_last = r_is_rd ? (r_step == 3'd4) : (r_step == 3'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_step_sel  = r_step;
        w_timer_nxt = r_timer;
        w_cmd_nxt   = r_cmd;
        w_tx_nxt    = r_tx;
        w_rd_nxt    = r_rd;
        w_go_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // busy stays up through the rw_done cycle
                if (r_done) begin
                    w_busy_nxt = 1'b0;
                end else if (wr_req || rd_req) begin
                    w_load      = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_step_nxt  = 3'd0;
                    w_go_nxt    = 1'b1;
                    w_cmd_nxt   = C_STA | C_WR;
                    w_tx_nxt    = {dev_id, 1'b0};
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (trans_done) begin
                    if (r_cmd[0]) begin
                        w_err_nxt = r_err | ack_o;
                    end
                    if (r_step == 3'd4) begin
                        w_rd_nxt = rx_data;
                    end
                    w_state_nxt = w_last ? S_FIN : S_NEXT;
                end else if (r_timer == TMAX) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_NEXT: begin
                w_step_sel  = (r_step == 3'd0 && !r_mode) ? 3'd2 : r_step + 3'd1;
                w_step_nxt  = w_step_sel;
                w_go_nxt    = 1'b1;
                w_state_nxt = S_ISSUE;
                case (w_step_sel)
                    3'd1: begin
                        w_cmd_nxt = C_WR;
                        w_tx_nxt  = r_addr[15:8];
                    end
                    3'd2: begin
                        w_cmd_nxt = C_WR;
                        w_tx_nxt  = r_addr[7:0];
                    end
                    3'd3: begin
                        w_cmd_nxt = r_is_rd ? (C_STA | C_WR) : (C_WR | C_STO);
                        w_tx_nxt  = r_is_rd ? {r_dev, 1'b1} : r_wdata;
                    end
                    default: begin
                        w_cmd_nxt = C_RD | C_NACK | C_STO;
                        w_tx_nxt  = 8'h00;
                    end
                endcase
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_cmd_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_timer <= '0;
            r_cmd   <= '0;
            r_tx    <= '0;
            r_rd    <= '0;
            r_go    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_dev   <= '0;
            r_mode  <= 1'b0;
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_timer <= w_timer_nxt;
            r_cmd   <= w_cmd_nxt;
            r_tx    <= w_tx_nxt;
            r_rd    <= w_rd_nxt;
            r_go    <= w_go_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            if (w_load) begin
                r_dev   <= dev_id;
                r_mode  <= addr_mode;
                r_is_rd <= !wr_req;
                r_addr  <= reg_addr;
                r_wdata <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_iic_reg_ctrl.sv
// Self-checking bench for iic_reg_ctrl: a reactive engine model plus a
// byte-sequence reference model derived from the register protocol.
module tb_iic_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req;
    logic [6:0]  dev_id;
    logic        addr_mode;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rw_done, err, busy;
    logic [5:0]  cmd;
    logic        go;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    logic        trans_done;
    logic        ack_o;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [5:0]  log_cmd[$];
    logic [7:0]  log_tx[$];
    int unsigned go_cyc[$];
    int unsigned last_td_cyc;
    int          eng_go_cnt = 0;
    int          eng_stall = 99;
    int          eng_nack = -1;
    int          stab_err = 0;
    logic [7:0]  eng_rx = 8'h00;

    logic [5:0]  exp_cmd[$];
    logic [7:0]  exp_tx[$];
    bit          exp_wr[$];
    logic [7:0]  model_rd = 8'h00;

    iic_reg_ctrl #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
        .dev_id(dev_id), .addr_mode(addr_mode), .reg_addr(reg_addr),
        .wr_data(wr_data), .rd_data(rd_data), .rw_done(rw_done),
        .err(err), .busy(busy), .cmd(cmd), .go(go), .tx_data(tx_data),
        .rx_data(rx_data), .trans_done(trans_done), .ack_o(ack_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: answers each go after a random delay unless stalled.
    initial begin
        int idx;
        int d;
        trans_done = 1'b0;
        ack_o = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (go === 1'b1) begin
                log_cmd.push_back(cmd);
                log_tx.push_back(tx_data);
                go_cyc.push_back(cyc);
                idx = eng_go_cnt;
                eng_go_cnt++;
                if (idx < eng_stall) begin
                    d = $urandom_range(1, 4);
                    repeat (d) begin
                        @(posedge clk);
                        #1;
                        if (go !== 1'b0) stab_err++;
                    end
                    if (cmd !== log_cmd[idx] || tx_data !== log_tx[idx]) stab_err++;
                    trans_done = 1'b1;
                    ack_o = (idx == eng_nack);
                    rx_data = eng_rx;
                    last_td_cyc = cyc;
                    @(posedge clk);
                    #1;
                    trans_done = 1'b0;
                    ack_o = 1'b0;
                end
            end
        end
    end

    task automatic build_exp(input bit rd, input logic [6:0] dev, input bit mode,
                             input logic [15:0] a, input logic [7:0] d);
        exp_cmd.delete();
        exp_tx.delete();
        exp_wr.delete();
        exp_cmd.push_back(6'h03); exp_tx.push_back({dev, 1'b0}); exp_wr.push_back(1);
        if (mode) begin
            exp_cmd.push_back(6'h01); exp_tx.push_back(a[15:8]); exp_wr.push_back(1);
        end
        exp_cmd.push_back(6'h01); exp_tx.push_back(a[7:0]); exp_wr.push_back(1);
        if (rd) begin
            exp_cmd.push_back(6'h03); exp_tx.push_back({dev, 1'b1}); exp_wr.push_back(1);
            exp_cmd.push_back(6'h2C); exp_tx.push_back(8'h00); exp_wr.push_back(0);
        end else begin
            exp_cmd.push_back(6'h09); exp_tx.push_back(d); exp_wr.push_back(1);
        end
    endtask

    task automatic run_req(input bit rd, input bit both, input bit extra,
                           input logic [6:0] dev, input bit mode,
                           input logic [15:0] a, input logic [7:0] d,
                           output bit done_ok, output logic got_err,
                           output logic [7:0] got_rd, output logic busy_mid,
                           output logic busy_after, output logic done_after,
                           output int unsigned req_cyc, output int unsigned done_cyc);
        int n;
        log_cmd.delete();
        log_tx.delete();
        go_cyc.delete();
        eng_go_cnt = 0;
        stab_err = 0;
        @(negedge clk);
        dev_id = dev; addr_mode = mode; reg_addr = a; wr_data = d;
        wr_req = !rd || both;
        rd_req = rd || both;
        req_cyc = cyc;
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        busy_mid = busy;
        if (extra) begin
            @(negedge clk);
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
        end
        n = 0;
        while (rw_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        done_ok = (rw_done === 1'b1);
        got_err = err;
        got_rd = rd_data;
        done_cyc = cyc;
        @(negedge clk);
        busy_after = busy;
        done_after = rw_done;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_req = 0; rd_req = 0; dev_id = 0; addr_mode = 0; reg_addr = 0; wr_data = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd, go, tx_data, rd_data, rw_done, err, busy} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got cmd=%h go=%b tx=%h rd=%h done=%b err=%b busy=%b want all 0",
                     cmd, go, tx_data, rd_data, rw_done, err, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        eng_nack = -1;
        build_exp(0, 7'h50, 0, 16'h0012, 8'hA5);
        run_req(0, 0, 0, 7'h50, 0, 16'h0012, 8'hA5, ok, e, r, bm, ba, da, rc, dc);
        checks++;
        if (!ok || log_cmd.size() != 3) begin
            errors++;
            $display("FAIL wr_basic_count got done=%0b gos=%0d want done=1 gos=3", ok, log_cmd.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_cmd[i] !== exp_cmd[i] || log_tx[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL wr_basic_byte%0d got %h/%h want %h/%h", i,
                             log_cmd[i], log_tx[i], exp_cmd[i], exp_tx[i]);
                end
            end
            checks++;
            if (go_cyc[0] != rc + 1 || dc - last_td_cyc != 2) begin
                errors++;
                $display("FAIL wr_basic_latency got go=%0d done=%0d want go=1 done=2",
                         go_cyc[0] - rc, dc - last_td_cyc);
            end
        end
        checks++;
        if (e !== 1'b0 || bm !== 1'b1 || ba !== 1'b0 || da !== 1'b0 || stab_err != 0) begin
            errors++;
            $display("FAIL wr_basic_flags got err=%b busy=%b/%b done_after=%b stab=%0d want 0,1/0,0,0",
                     e, bm, ba, da, stab_err);
        end
    endtask

    task automatic test_read_basic();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        eng_nack = -1;
        eng_rx = 8'h3C;
        build_exp(1, 7'h50, 1, 16'h0345, 8'h00);
        run_req(1, 0, 0, 7'h50, 1, 16'h0345, 8'h00, ok, e, r, bm, ba, da, rc, dc);
        model_rd = 8'h3C;
        checks++;
        if (!ok || log_cmd.size() != 5) begin
            errors++;
            $display("FAIL rd_basic_count got done=%0b gos=%0d want done=1 gos=5", ok, log_cmd.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_cmd[i] !== exp_cmd[i] || log_tx[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL rd_basic_byte%0d got %h/%h want %h/%h", i,
                             log_cmd[i], log_tx[i], exp_cmd[i], exp_tx[i]);
                end
            end
            checks++;
            if (log_cmd[4] !== 6'b101100) begin
                errors++;
                $display("FAIL rd_basic_lastcmd got %b want 101100", log_cmd[4]);
            end
        end
        checks++;
        if (r !== 8'h3C || e !== 1'b0 || da !== 1'b0 || stab_err != 0) begin
            errors++;
            $display("FAIL rd_basic_data got rd=%h err=%b done_after=%b stab=%0d want 3c,0,0,0",
                     r, e, da, stab_err);
        end
    endtask

    task automatic test_nack();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        eng_nack = 1;
        build_exp(0, 7'h2B, 0, 16'h0077, 8'h5A);
        run_req(0, 0, 0, 7'h2B, 0, 16'h0077, 8'h5A, ok, e, r, bm, ba, da, rc, dc);
        eng_nack = -1;
        checks++;
        if (!ok || log_cmd.size() != 3 || e !== 1'b1) begin
            errors++;
            $display("FAIL nack_addr got done=%0b gos=%0d err=%b want 1,3,1", ok, log_cmd.size(), e);
        end else begin
            checks++;
            if (log_cmd[2] !== 6'h09 || log_tx[2] !== 8'h5A) begin
                errors++;
                $display("FAIL nack_stop got %h/%h want 09/5a", log_cmd[2], log_tx[2]);
            end
        end
    endtask

    task automatic test_both_req();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        eng_nack = -1;
        build_exp(0, 7'h11, 1, 16'hBEEF, 8'hC3);
        run_req(0, 1, 1, 7'h11, 1, 16'hBEEF, 8'hC3, ok, e, r, bm, ba, da, rc, dc);
        checks++;
        if (!ok || log_cmd.size() != 4 || da !== 1'b0) begin
            errors++;
            $display("FAIL both_req got done=%0b gos=%0d done_after=%b want 1,4,0", ok, log_cmd.size(), da);
        end else begin
            checks++;
            if (log_cmd[3] !== 6'h09 || log_tx[3] !== 8'hC3 || log_tx[1] !== 8'hBE) begin
                errors++;
                $display("FAIL both_req_seq got %h/%h hi=%h want 09/c3 hi=be",
                         log_cmd[3], log_tx[3], log_tx[1]);
            end
        end
    endtask

    task automatic test_random();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        bit rd, mode, exp_err;
        logic [6:0] dev; logic [15:0] a; logic [7:0] d;
        int n;
        for (int it = 0; it < 20; it++) begin
            rd = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            dev = 7'($urandom);
            a = 16'($urandom);
            d = 8'($urandom);
            eng_rx = 8'($urandom);
            build_exp(rd, dev, mode, a, d);
            n = exp_cmd.size();
            eng_nack = $urandom_range(0, n);
            exp_err = (eng_nack < n) && exp_wr[eng_nack];
            run_req(rd, 0, 0, dev, mode, a, d, ok, e, r, bm, ba, da, rc, dc);
            if (rd) model_rd = eng_rx;
            checks++;
            if (!ok || log_cmd.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count got done=%0b gos=%0d want 1,%0d", it, ok, log_cmd.size(), n);
                continue;
            end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (log_cmd[i] !== exp_cmd[i] || (exp_wr[i] && log_tx[i] !== exp_tx[i])) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d got %h/%h want %h/%h", it, i,
                             log_cmd[i], log_tx[i], exp_cmd[i], exp_tx[i]);
                end
            end
            checks++;
            if (e !== exp_err || r !== model_rd || stab_err != 0 || dc - last_td_cyc != 2) begin
                errors++;
                $display("FAIL rand%0d_result got err=%b rd=%h stab=%0d lat=%0d want %b,%h,0,2",
                         it, e, r, stab_err, dc - last_td_cyc, exp_err, model_rd);
            end
        end
        eng_nack = -1;
    endtask

    task automatic test_timeout();
        bit ok; logic e, bm, ba, da; logic [7:0] r; int unsigned rc, dc;
        eng_stall = 0;
        run_req(0, 0, 0, 7'h33, 0, 16'h0001, 8'h99, ok, e, r, bm, ba, da, rc, dc);
        eng_stall = 99;
        checks++;
        if (!ok || e !== 1'b1 || log_cmd.size() != 1) begin
            errors++;
            $display("FAIL timeout_flag got done=%0b err=%b gos=%0d want 1,1,1", ok, e, log_cmd.size());
        end else begin
            checks++;
            if (dc - go_cyc[0] != 102) begin
                errors++;
                $display("FAIL timeout_latency got %0d want 102", dc - go_cyc[0]);
            end
        end
        checks++;
        if (r !== model_rd || ba !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state got rd=%h busy=%b want %h,0", r, ba, model_rd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        log_cmd.delete(); log_tx.delete(); go_cyc.delete();
        eng_go_cnt = 0;
        eng_stall = 2;
        @(negedge clk);
        dev_id = 7'h44; addr_mode = 1'b1; reg_addr = 16'h1234; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (eng_go_cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (eng_go_cnt != 3) begin
            errors++;
            $display("FAIL rstmid_reach got gos=%0d want 3", eng_go_cnt);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd, go, tx_data, rd_data, rw_done, err, busy} !== 26'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got cmd=%h go=%b tx=%h rd=%h done=%b err=%b busy=%b want all 0",
                     cmd, go, tx_data, rd_data, rw_done, err, busy);
        end
        rst = 1'b0;
        model_rd = 8'h00;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (rw_done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || eng_go_cnt != 3) begin
            errors++;
            $display("FAIL rstmid_silent got activity=%0d gos=%0d want 0,3", seen, eng_go_cnt);
        end
        eng_stall = 99;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_nack();
        test_both_req();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
